// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder block: channel FSM states
// and the stall LFSR seed/taps (used only when MEM_RESPONDER_STALL_EN is defined).
package mem_responder_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        READ_WAIT  = 3'd1,
        WRITE_WAIT = 3'd2,
        RESPOND    = 3'd3,
        DROP       = 3'd4
    } chan_state_e;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Feedback taps 8,6,5,4 expressed as bit positions 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mem_responder_channel.sv
// One request channel of mem_responder: FSM, latency counter and latched request.
// Exports a write-commit request and the address it needs read data for.
module mem_responder_channel
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 read_valid_i,
    input  logic [ADDR_BITS-1:0] read_address_i,
    input  logic                 write_valid_i,
    input  logic [ADDR_BITS-1:0] write_address_i,
    input  logic [DATA_BITS-1:0] write_data_i,
    input  logic [1:0]           extra_wait_i,
    output logic                 read_ready_o,
    output logic [DATA_BITS-1:0] read_data_o,
    output logic                 write_ready_o,
    output logic                 commit_en_o,
    output logic [ADDR_BITS-1:0] commit_addr_o,
    output logic [DATA_BITS-1:0] commit_data_o,
    output logic [ADDR_BITS-1:0] rd_addr_o,
    input  logic [DATA_BITS-1:0] rd_data_i
);

    localparam int CNT_W = $clog2(LATENCY + 4);

    chan_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 is_write_q, is_write_d;
    logic                 read_ready_q, read_ready_d;
    logic                 write_ready_q, write_ready_d;
    logic [DATA_BITS-1:0] read_data_q, read_data_d;
    logic [CNT_W-1:0]     wait_s;
    logic                 serviced_valid_s;

    // Cycles spent in a WAIT state; zero means respond directly from IDLE
    assign wait_s           = CNT_W'(LATENCY - 1) + CNT_W'(extra_wait_i);
    assign serviced_valid_s = is_write_q ? write_valid_i : read_valid_i;

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            is_write_q    <= 1'b0;
            read_ready_q  <= 1'b0;
            write_ready_q <= 1'b0;
            read_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            is_write_q    <= is_write_d;
            read_ready_q  <= read_ready_d;
            write_ready_q <= write_ready_d;
            read_data_q   <= read_data_d;
        end
    end

    // Next-state logic; writes take priority over reads at acceptance
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        is_write_d = is_write_q;
        case (state_q)
            IDLE: begin
                if (write_valid_i) begin
                    is_write_d = 1'b1;
                    addr_d     = write_address_i;
                    data_d     = write_data_i;
                    cnt_d      = wait_s;
                    state_d    = (wait_s == '0) ? RESPOND : WRITE_WAIT;
                end else if (read_valid_i) begin
                    is_write_d = 1'b0;
                    addr_d     = read_address_i;
                    cnt_d      = wait_s;
                    state_d    = (wait_s == '0) ? RESPOND : READ_WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            READ_WAIT, WRITE_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = RESPOND;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = state_q;
                end
            end
            RESPOND: state_d = DROP;
            DROP: begin
                if (serviced_valid_s) begin
                    state_d = DROP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: readys and read data are registered on entry to RESPOND
    always_comb begin
        read_ready_d  = (state_d == RESPOND) && !is_write_d;
        write_ready_d = (state_d == RESPOND) && is_write_d;
        read_data_d   = read_ready_d ? rd_data_i : read_data_q;
    end

    assign read_ready_o  = read_ready_q;
    assign write_ready_o = write_ready_q;
    assign read_data_o   = read_data_q;
    assign commit_en_o   = (state_q == RESPOND) && is_write_q;
    assign commit_addr_o = addr_q;
    assign commit_data_o = data_q;
    assign rd_addr_o     = addr_d;

endmodule

// File: rtl/mem_responder.sv
// On-chip memory responder: one storage array shared by NUM_CHANNELS channels
// plus a backdoor load port. Define MEM_RESPONDER_STALL_EN for LFSR-driven extra latency.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 1,
    parameter int LATENCY      = 2
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CHANNELS-1:0]                  read_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   read_address,
    output logic [NUM_CHANNELS-1:0]                  read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   read_data,
    input  logic [NUM_CHANNELS-1:0]                  write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   write_data,
    output logic [NUM_CHANNELS-1:0]                  write_ready,
    input  logic                                     load_en,
    input  logic [ADDR_BITS-1:0]                     load_address,
    input  logic [DATA_BITS-1:0]                     load_data
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_BITS-1:0]                   mem_q [DEPTH];
    logic [NUM_CHANNELS-1:0]                commit_en_s;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] commit_addr_s;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] commit_data_s;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] rd_addr_s;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] rd_data_s;
    logic                                   we_s;
    logic [ADDR_BITS-1:0]                   waddr_s;
    logic [DATA_BITS-1:0]                   wdata_s;
    logic [1:0]                             extra_wait_s;

`ifdef MEM_RESPONDER_STALL_EN
    logic [7:0] lfsr_q;

    // Free-running stall LFSR; its low bits pick the extra wait at acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign extra_wait_s = lfsr_q[1:0];
`else
    assign extra_wait_s = 2'b00;
`endif

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        mem_responder_channel #(
            .ADDR_BITS(ADDR_BITS),
            .DATA_BITS(DATA_BITS),
            .LATENCY  (LATENCY)
        ) u_chan (
            .clk_i          (clk),
            .reset_i        (reset),
            .read_valid_i   (read_valid[c]),
            .read_address_i (read_address[c]),
            .write_valid_i  (write_valid[c]),
            .write_address_i(write_address[c]),
            .write_data_i   (write_data[c]),
            .extra_wait_i   (extra_wait_s),
            .read_ready_o   (read_ready[c]),
            .read_data_o    (read_data[c]),
            .write_ready_o  (write_ready[c]),
            .commit_en_o    (commit_en_s[c]),
            .commit_addr_o  (commit_addr_s[c]),
            .commit_data_o  (commit_data_s[c]),
            .rd_addr_o      (rd_addr_s[c]),
            .rd_data_i      (rd_data_s[c])
        );
    end

    // Single write port: backdoor load beats channels, lowest channel index beats higher
    always_comb begin
        we_s    = 1'b0;
        waddr_s = '0;
        wdata_s = '0;
        for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
            waddr_s = commit_en_s[c] ? commit_addr_s[c] : waddr_s;
            wdata_s = commit_en_s[c] ? commit_data_s[c] : wdata_s;
            we_s    = we_s | commit_en_s[c];
        end
        waddr_s = load_en ? load_address : waddr_s;
        wdata_s = load_en ? load_data : wdata_s;
        we_s    = we_s | load_en;
    end

    // Storage array; intentionally not cleared by reset
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_q[waddr_s] <= wdata_s;
        end
    end

    // Read data is captured one edge before RESPOND, so forward the write landing on that edge
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            rd_data_s[c] = (we_s && (waddr_s == rd_addr_s[c])) ? wdata_s : mem_q[rd_addr_s[c]];
        end
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the valid/ready memory interface that the GPU's memory controllers drive toward external data and program memory.
- Owns a single storage array and serves NUM_CHANNELS independent request channels.
- Each channel answers a request with a one-cycle ready pulse after a fixed latency.
- Used as the synthesizable on-chip memory model for sim/FPGA bring-up; a backdoor load port preloads programs and data.

Parameters:
- ADDR_BITS, 8, address width; array depth = 2**ADDR_BITS.
- DATA_BITS, 8, word width (16 when instanced as program memory).
- NUM_CHANNELS, 1, number of initiator channels (must be >= 1).
- LATENCY, 2, cycles from request acceptance to ready pulse (must be >= 1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- read_valid  in  NUM_CHANNELS  per-channel read request; held until the ready pulse.
- read_address  in  [NUM_CHANNELS] x ADDR_BITS  read address.
- read_ready  out  NUM_CHANNELS  one-cycle read completion pulse.
- read_data  out  [NUM_CHANNELS] x DATA_BITS  read data; valid when read_ready is high, held until the next read completion on that channel.
- write_valid  in  NUM_CHANNELS  per-channel write request.
- write_address  in  [NUM_CHANNELS] x ADDR_BITS  write address.
- write_data  in  [NUM_CHANNELS] x DATA_BITS  write data.
- write_ready  out  NUM_CHANNELS  one-cycle write completion pulse.
- load_en  in  1  backdoor write strobe (testbench/boot).
- load_address  in  ADDR_BITS  backdoor address.
- load_data  in  DATA_BITS  backdoor data.

Behaviour:
- Reset (synchronous, active-high, clk): every channel FSM goes to IDLE; read_ready=0, write_ready=0, read_data=0, counters=0.
- Reset does NOT clear the storage array.
- Reset mid-request abandons the request; a write that has not reached its ready cycle is not committed.
- Per-channel FSM:
  - IDLE: if write_valid, latch write address/data, load counter with LATENCY-1, go to WRITE_WAIT. Else if read_valid, latch the address, load counter, go to READ_WAIT.
  - Write has priority if both valids are high in the same cycle; the read is served after the write completes.
  - READ_WAIT / WRITE_WAIT: decrement the counter; at 0, go to RESPOND.
  - RESPOND: pulse the matching ready for exactly one cycle. For a read, read_data = array[latched addr] in the same cycle. For a write, the array is updated at the end of this cycle. Then go to DROP.
  - DROP: wait until the serviced valid is low, then IDLE. No second response is issued while valid stays high.
- Latency: valid first high at cycle T → ready high at cycle T+LATENCY. Minimum request-to-request spacing is LATENCY+2 cycles.
- Address and data are latched at acceptance. Later changes on the inputs are ignored until the next acceptance.
- Same-cycle array collisions, resolved in this priority order:
  1. Multiple channels writing in their RESPOND cycle: lowest channel index wins; the others' ready still pulses, their data is dropped.
  2. load_en with a channel write in the same cycle: load_en wins.
  3. A read in RESPOND while a write to the same address commits in that cycle: the read returns the old value (read-before-write).
- Address arithmetic is unsigned, with no wrap or bounds check; every ADDR_BITS value is valid.
- A valid that deasserts before its ready pulse is a protocol violation. The channel still completes the transaction.

Optional Feature:
- Macro: MEM_RESPONDER_STALL_EN.
- When defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every cycle. At acceptance, each channel adds lfsr[1:0] (0–3) extra wait cycles, which stresses initiator backpressure. The sequence is deterministic per seed.
- When undefined: latency is exactly LATENCY and no LFSR logic is instantiated.

Decomposition:
- Package mem_responder_pkg:
  - channel state enum {IDLE, READ_WAIT, WRITE_WAIT, RESPOND, DROP}.
  - LFSR seed and tap constants.
- Sub-module mem_responder_channel: one FSM plus latency counter plus latched address/data/op. It exports a commit request (en, addr, data) and receives read data from the top.
- The top holds the array, the write-priority mux, the backdoor port and the LFSR.

Test Plan:
- Preload array[8'h10]=8'h3C via load_en; ch0 read_valid addr 8'h10 at cycle T, LATENCY=2 → read_ready pulses only at T+2, read_data=8'h3C, held after valid drops.
- ch0 write 8'h10←8'h7F, then a read of 8'h10 → write_ready pulse at T+2, then read returns 8'h7F.
- NUM_CHANNELS=2, both write addr 8'h20 (ch0 8'h11, ch1 8'h22) in the same cycle → both readys pulse, array[8'h20]=8'h11.
- Initiator holds read_valid 5 cycles past ready → exactly one ready pulse; next request is accepted only after valid has been low for 1 cycle.
- Reset asserted during WRITE_WAIT → readys stay 0, array unchanged, next request completes normally with latency LATENCY.
- With MEM_RESPONDER_STALL_EN: 16 back-to-back reads → each latency falls in [LATENCY, LATENCY+3] and matches the reference LFSR model from seed 8'hA5.
